// File: rtl/temp_sensor_pkg.sv
// Shared types for the temperature-sensor SPI responder: FSM states, default width, pin idle levels.
// TEMP_SENSOR_CMD_EN adds the CMD state used by the optional command phase.
package temp_sensor_pkg;

   localparam int   DATA_W_DEFAULT = 16;
   localparam logic CS_N_IDLE      = 1'b1;
   localparam logic SCK_IDLE       = 1'b0;
   localparam logic SIO_IDLE       = 1'b0;

`ifdef TEMP_SENSOR_CMD_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_CMD  = 2'd2,
      ST_WAIT = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_WAIT = 2'd3
   } state_e;
`endif

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by an edge-detect register.
// Rise/fall pulses are valid in the cycle after the last sync stage changes.
module spi_pin_sync #(
   parameter int   STAGES   = 2,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Resetting to the idle level keeps reset release from looking like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{IDLE_LVL}};
         prev_q <= IDLE_LVL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/temp_sensor_spi_responder.sv
// SPI responder that shifts a held temperature word out MSB first on sck falls.
// Define TEMP_SENSOR_CMD_EN to accept a DATA_W-bit command on sck rises after the read phase.
module temp_sensor_spi_responder
   import temp_sensor_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] temp_in,
   input  logic              temp_load,
   input  logic              cs_n,
   input  logic              sck,
   input  logic              sio_in,
   output logic              sio_out,
   output logic              sio_oe,
   output logic              busy,
   output logic              frame_done,
   output logic [DATA_W-1:0] cmd_data,
   output logic              cmd_valid,
   output logic [1:0]        state_dbg
);

   localparam int              CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef TEMP_SENSOR_CMD_EN
   localparam state_e READ_NEXT = ST_CMD;
`else
   localparam state_e READ_NEXT = ST_WAIT;
`endif

   state_e            state_q, state_d;
   logic [DATA_W-1:0] holding_reg, shift_reg;
   logic [CNT_W-1:0]  bit_cnt;
   logic              cs_level, cs_rise, cs_fall;
   logic              sck_level, sck_rise, sck_fall;
   logic              read_done;
   logic              unused_levels;

   spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(CS_N_IDLE)) u_cs_sync (
      .clk(clk), .rst_n(rst_n), .pin(cs_n),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );

   spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(SCK_IDLE)) u_sck_sync (
      .clk(clk), .rst_n(rst_n), .pin(sck),
      .level(sck_level), .rise(sck_rise), .fall(sck_fall)
   );

   assign unused_levels = cs_level ^ sck_level;

`ifdef TEMP_SENSOR_CMD_EN
   logic [DATA_W-1:0] cmd_shift;
   logic [CNT_W-1:0]  cmd_cnt;
   logic              sio_level, sio_rise, sio_fall;
   logic              unused_sio_edges;

   spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(SIO_IDLE)) u_sio_sync (
      .clk(clk), .rst_n(rst_n), .pin(sio_in),
      .level(sio_level), .rise(sio_rise), .fall(sio_fall)
   );

   assign unused_sio_edges = sio_rise ^ sio_fall;

   // WAIT is only reachable through CMD, so a cs_n rise there means a whole command arrived.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_shift <= '0;
         cmd_cnt   <= '0;
         cmd_data  <= '0;
         cmd_valid <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         if (cs_rise) begin
            if (state_q == ST_WAIT) begin
               cmd_data  <= cmd_shift;
               cmd_valid <= 1'b1;
            end
         end else if (state_q == ST_IDLE && cs_fall) begin
            cmd_cnt <= '0;
         end else if (state_q == ST_CMD && sck_rise) begin
            cmd_shift <= {cmd_shift[DATA_W-2:0], sio_level};
            cmd_cnt   <= cmd_cnt + CNT_ONE;
         end
      end
   end
`else
   logic unused_sio;

   assign unused_sio = sio_in;
   assign cmd_data   = '0;
   assign cmd_valid  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cs_fall) state_d = ST_READ;
         ST_READ: if (sck_fall && bit_cnt == LAST_BIT) state_d = READ_NEXT;
`ifdef TEMP_SENSOR_CMD_EN
         ST_CMD:  if (sck_rise && cmd_cnt == LAST_BIT) state_d = ST_WAIT;
`endif
         default: state_d = state_q;
      endcase
      if (cs_rise) state_d = ST_IDLE;
   end

   assign read_done = (state_q != ST_IDLE) && (state_q != ST_READ);

   // shift_reg is cleared on cs_n rise so sio_out is 0 even after an aborted read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         holding_reg <= '0;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (temp_load) holding_reg <= temp_in;
         if (cs_rise) begin
            shift_reg  <= '0;
            frame_done <= read_done;
         end else if (state_q == ST_IDLE && cs_fall) begin
            shift_reg <= temp_load ? temp_in : holding_reg;
            bit_cnt   <= '0;
         end else if (state_q == ST_READ && sck_fall) begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt + CNT_ONE;
         end
      end
   end

   assign sio_out   = shift_reg[DATA_W-1];
   assign sio_oe    = (state_q == ST_READ);
   assign busy      = (state_q != ST_IDLE);
   assign state_dbg = state_q;

endmodule
